// File: rtl/stl_rr_sched_pkg.sv
// rtl/stl_rr_sched_pkg.sv - shared types and helpers for the round-robin scheduler
package stl_rr_sched_pkg;

  typedef enum logic {ST_IDLE, ST_LOCK} rr_state_e;

  // Explicit modulo increment so a pointer at n-1 wraps to 0 for any n.
  function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stl_rr_sched_pick.sv
// rtl/stl_rr_sched_pick.sv - combinational rotating find-first-one from start_pos
module stl_rr_pick
  import stl_rr_sched_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start_pos,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] lo_mask;
  logic [2*N-1:0] masked;
  logic [W:0]     pos;

  // Doubled request vector with the bits below start_pos removed; the lowest
  // remaining bit is the rotating winner, folded back into 0..N-1.
  always_comb begin
    dbl     = {req, req};
    lo_mask = ((2*N)'(1) << start_pos) - (2*N)'(1);
    masked  = dbl & ~lo_mask;
    found   = |req;
    pos     = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) pos = (W+1)'(i);
    end
    if (pos >= (W+1)'(N)) idx = W'(pos - (W+1)'(N));
    else                  idx = W'(pos);
  end

endmodule

// File: rtl/stl_rr_sched.sv
// rtl/stl_rr_sched.sv - packet-locking round-robin scheduler, optional stats via STL_RR_SCHED_STAT_EN
module stl_rr_sched
  import stl_rr_sched_pkg::*;
#(
  parameter int REQ_N  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(REQ_N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_N-1:0]               req_i,
  input  logic [REQ_N-1:0][DATA_W-1:0]   req_data_i,
  input  logic [REQ_N-1:0]               req_last_i,
  output logic [REQ_N-1:0]               ack_o,
  output logic                           out_vld_o,
  input  logic                           out_rdy_i,
  output logic [DATA_W-1:0]              out_data_o,
  output logic [IDX_W-1:0]               out_idx_o,
  output logic                           out_last_o
`ifdef STL_RR_SCHED_STAT_EN
  ,
  output logic [REQ_N-1:0][15:0]         grant_cnt_o
`endif
);

  rr_state_e        state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             ld;
  logic             accept;
  logic [IDX_W-1:0] win_idx;
  logic             win_last;

  stl_rr_pick #(.N(REQ_N), .W(IDX_W)) u_pick (
    .req       (req_i),
    .start_pos (ptr),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Winner selection: rotating search when idle, the lock owner otherwise.
  always_comb begin
    ld       = !out_vld_o | out_rdy_i;
    win_idx  = (state == ST_IDLE) ? pick_idx : owner;
    accept   = ld && !rst && ((state == ST_IDLE) ? pick_found : req_i[owner]);
    win_last = req_last_i[win_idx];
    ack_o    = '0;
    if (accept) ack_o = REQ_N'(1) << win_idx;
  end

  // Lock FSM, pointer advance and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      out_vld_o  <= 1'b0;
      out_data_o <= '0;
      out_idx_o  <= '0;
      out_last_o <= 1'b0;
    end else if (accept) begin
      out_vld_o  <= 1'b1;
      out_data_o <= req_data_i[win_idx];
      out_idx_o  <= win_idx;
      out_last_o <= win_last;
      if (win_last) begin
        ptr   <= IDX_W'(rr_inc(32'(win_idx), REQ_N));
        state <= ST_IDLE;
      end else begin
        owner <= win_idx;
        state <= ST_LOCK;
      end
    end else if (ld) begin
      out_vld_o <= 1'b0;
    end
  end

`ifdef STL_RR_SCHED_STAT_EN
  // Per-requester count of completed packets, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_o <= '0;
    end else begin
      for (int k = 0; k < REQ_N; k++) begin
        if (accept && win_last && (win_idx == IDX_W'(k)) && (grant_cnt_o[k] != 16'hFFFF))
          grant_cnt_o[k] <= grant_cnt_o[k] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stl_rr_sched.sv
// tb/tb_stl_rr_sched.sv - directed self-checking bench for stl_rr_sched
module tb_stl_rr_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]       req4, last4, ack4;
  logic [3:0][7:0]  data4;
  logic             vld4, rdy4, olast4;
  logic [7:0]       odata4;
  logic [1:0]       oidx4;

  logic [4:0]       req5, last5, ack5;
  logic [4:0][7:0]  data5;
  logic             vld5, rdy5, olast5;
  logic [7:0]       odata5;
  logic [2:0]       oidx5;

`ifdef STL_RR_SCHED_STAT_EN
  logic [3:0][15:0] cnt4;
  logic [4:0][15:0] cnt5;
`endif

  int checks = 0;
  int errors = 0;

  stl_rr_sched #(.REQ_N(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .req_i(req4), .req_data_i(data4), .req_last_i(last4),
    .ack_o(ack4), .out_vld_o(vld4), .out_rdy_i(rdy4), .out_data_o(odata4),
    .out_idx_o(oidx4), .out_last_o(olast4)
`ifdef STL_RR_SCHED_STAT_EN
    , .grant_cnt_o(cnt4)
`endif
  );

  stl_rr_sched #(.REQ_N(5), .DATA_W(8)) dut5 (
    .clk(clk), .rst(rst), .req_i(req5), .req_data_i(data5), .req_last_i(last5),
    .ack_o(ack5), .out_vld_o(vld5), .out_rdy_i(rdy5), .out_data_o(odata5),
    .out_idx_o(oidx5), .out_last_o(olast5)
`ifdef STL_RR_SCHED_STAT_EN
    , .grant_cnt_o(cnt5)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat launched at negedge; ack checked combinationally before the edge.
  task automatic drive4(input logic [3:0] r, input logic [3:0] l, input logic rd, input logic [3:0] exp_ack);
    @(negedge clk);
    req4 = r; last4 = l; rdy4 = rd;
    #1;
    chk("ack4", ack4, exp_ack);
  endtask

  task automatic out4(input logic v, input logic [1:0] i, input logic [7:0] d, input logic l);
    @(posedge clk); #1;
    chk("vld4", vld4, v);
    chk("idx4", oidx4, i);
    chk("data4", odata4, d);
    chk("last4", olast4, l);
  endtask

  task automatic drive5(input logic [4:0] r, input logic [4:0] exp_ack, input logic [2:0] exp_idx);
    @(negedge clk);
    req5 = r;
    #1;
    chk("ack5", ack5, exp_ack);
    @(posedge clk); #1;
    chk("vld5", vld5, 1'b1);
    chk("idx5", oidx5, exp_idx);
    chk("data5", odata5, 8'h50 + 8'(exp_idx));
  endtask

  initial begin
    rst = 1'b1;
    req4 = 4'($urandom); last4 = 4'($urandom); rdy4 = 1'b1;
    req5 = '0; last5 = 5'b11111; rdy5 = 1'b1;
    for (int k = 0; k < 4; k++) data4[k] = 8'h10 * 8'(k + 1);
    for (int k = 0; k < 5; k++) data5[k] = 8'h50 + 8'(k);

    // Reset held three cycles with random requests
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_vld", vld4, 1'b0);
      chk("rst_data", odata4, 8'h00);
      chk("rst_idx", oidx4, 2'd0);
      chk("rst_last", olast4, 1'b0);
      chk("rst_ack", ack4, 4'b0000);
      req4 = 4'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; req4 = '0;
    #1;
    chk("post_rst_ack", ack4, 4'b0000);
    @(posedge clk); #1;
    chk("post_rst_vld", vld4, 1'b0);
    chk("post_rst_data", odata4, 8'h00);

    // Round robin across all four ports, single-beat packets
    for (int i = 0; i < 5; i++) begin
      drive4(4'b1111, 4'b1111, 1'b1, 4'(1 << (i % 4)));
      out4(1'b1, 2'(i % 4), 8'h10 * 8'((i % 4) + 1), 1'b1);
    end

    // Lock: port1 three-beat packet with a hole, port2 waits (ptr=1)
    data4[1] = 8'hA0;
    drive4(4'b0110, 4'b0000, 1'b1, 4'b0010);
    out4(1'b1, 2'd1, 8'hA0, 1'b0);
    drive4(4'b0100, 4'b0000, 1'b1, 4'b0000);
    out4(1'b0, 2'd1, 8'hA0, 1'b0);
    data4[1] = 8'hA1;
    drive4(4'b0110, 4'b0000, 1'b1, 4'b0010);
    out4(1'b1, 2'd1, 8'hA1, 1'b0);
    data4[1] = 8'hA2;
    drive4(4'b0110, 4'b0010, 1'b1, 4'b0010);
    out4(1'b1, 2'd1, 8'hA2, 1'b1);
    drive4(4'b0110, 4'b0110, 1'b1, 4'b0100);
    out4(1'b1, 2'd2, 8'h30, 1'b1);
    drive4(4'b0110, 4'b0110, 1'b1, 4'b0010);
    out4(1'b1, 2'd1, 8'hA2, 1'b1);

    // Backpressure: port3 beat held for five stalled cycles (ptr=2)
    drive4(4'b1000, 4'b1000, 1'b1, 4'b1000);
    out4(1'b1, 2'd3, 8'h40, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive4(4'b0001, 4'b0001, 1'b0, 4'b0000);
      out4(1'b1, 2'd3, 8'h40, 1'b1);
    end
    drive4(4'b0001, 4'b0001, 1'b1, 4'b0001);
    out4(1'b1, 2'd0, 8'h10, 1'b1);
    // Drain: valid drops, data holds
    drive4(4'b0000, 4'b0000, 1'b1, 4'b0000);
    out4(1'b0, 2'd0, 8'h10, 1'b1);

    // Wrap with REQ_N=5: move ptr to 4, then alternate 4,0,4,0
    drive5(5'b01000, 5'b01000, 3'd3);
    drive5(5'b10001, 5'b10000, 3'd4);
    drive5(5'b10001, 5'b00001, 3'd0);
    drive5(5'b10001, 5'b10000, 3'd4);
    drive5(5'b10001, 5'b00001, 3'd0);
    @(negedge clk);
    req5 = '0;

`ifdef STL_RR_SCHED_STAT_EN
    // Saturation of the port-0 packet counter
    @(negedge clk);
    req4 = 4'b0001; last4 = 4'b0001; rdy4 = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt0_sat", cnt4[0], 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt0_hold", cnt4[0], 16'hFFFF);
    @(negedge clk);
    req4 = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
